// File: rtl/lock_pkg.sv
// Shared types and constants for the passcode entry controller.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_ERROR    = 2'd3
    } lock_state_e;

    localparam logic [3:0] BLANK_DIGIT        = 4'hE;
    localparam int         MAX_DISPLAY_DIGITS = 6;

endpackage

// File: rtl/passcode_entry_controller_if.sv
// Keypad-side strobes and display-side results of the passcode controller.
interface passcode_entry_controller_if #(
    parameter int PASSCODE_WIDTH = 16
);
    logic                      keyValid;
    logic [3:0]                keyDigit;
    logic                      keyEnter;
    logic                      keyClear;
    logic [PASSCODE_WIDTH-1:0] userEntry;
    logic [2:0]                digitCount;
    logic                      error;
    logic                      unlocked;

    modport master (
        output keyValid, keyDigit, keyEnter, keyClear,
        input  userEntry, digitCount, error, unlocked
    );

    modport slave (
        input  keyValid, keyDigit, keyEnter, keyClear,
        output userEntry, digitCount, error, unlocked
    );
endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             count_i,
    output logic             done_o
);
    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (count_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/passcode_entry_controller.sv
// Keypad passcode collector and checker; define LOCKOUT_EN for
// extended error hold after MAX_ATTEMPTS consecutive failures.
module passcode_entry_controller
    import lock_pkg::*;
#(
    parameter int                        PASSCODE_LENGTH = 4,
    parameter int                        PASSCODE_WIDTH  = 4 * PASSCODE_LENGTH,
    parameter logic [PASSCODE_WIDTH-1:0] PASSCODE        = 16'h1234,
    parameter int                        ERROR_CYCLES    = 50_000_000,
    parameter int                        MAX_ATTEMPTS    = 3,
    parameter int                        LOCKOUT_CYCLES  = 500_000_000
) (
    input logic                         clock,
    input logic                         reset,
    passcode_entry_controller_if.slave  bus
);
    localparam logic [PASSCODE_WIDTH-1:0] BLANK = {PASSCODE_LENGTH{BLANK_DIGIT}};
    localparam logic [2:0]                FULL  = 3'(PASSCODE_LENGTH);
    localparam int                        FW    = $clog2(MAX_ATTEMPTS + 1);

`ifdef LOCKOUT_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    localparam int TIMER_MAX = ERROR_CYCLES + (LOCK_ON ? LOCKOUT_CYCLES : 0);
    localparam int TW        = $clog2(TIMER_MAX) + 1;

    lock_state_e               state_q;
    logic [PASSCODE_WIDTH-1:0] entry_q;
    logic [2:0]                count_q;
    logic                      error_q;
    logic                      unlocked_q;
    logic [FW-1:0]             fails_q;

    logic          full;
    logic          match;
    logic          digit_ok;
    logic          go_err;
    logic          lockout;
    logic          timer_done;
    logic [TW-1:0] timer_val;

    assign full     = (count_q == FULL);
    assign match    = (entry_q == PASSCODE);
    assign digit_ok = (bus.keyDigit <= 4'd9);
    assign lockout  = LOCK_ON && (fails_q == FW'(MAX_ATTEMPTS - 1));

    // Both failure paths arm the error timer on the edge that enters ERROR.
    assign go_err = (state_q == ST_ENTRY && !bus.keyClear &&
                     bus.keyEnter && !full) ||
                    (state_q == ST_CHECK && !match);

    assign timer_val = lockout ? TW'(ERROR_CYCLES + LOCKOUT_CYCLES - 1)
                               : TW'(ERROR_CYCLES - 1);

    cycle_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (go_err),
        .load_val_i (timer_val),
        .count_i    (state_q == ST_ERROR),
        .done_o     (timer_done)
    );

`ifdef LOCKOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fails_q <= '0;
        end else if (go_err) begin
            fails_q <= lockout ? '0 : fails_q + 1'b1;
        end else if (state_q == ST_CHECK && match) begin
            fails_q <= '0;
        end
    end
`else
    assign fails_q = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_ENTRY;
            entry_q    <= BLANK;
            count_q    <= '0;
            error_q    <= 1'b0;
            unlocked_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_ENTRY: begin
                    if (bus.keyClear) begin
                        entry_q <= BLANK;
                        count_q <= '0;
                    end else if (bus.keyEnter) begin
                        if (full) begin
                            state_q <= ST_CHECK;
                        end else begin
                            state_q <= ST_ERROR;
                            error_q <= 1'b1;
                        end
                    end else if (bus.keyValid && digit_ok && !full) begin
                        entry_q <= (entry_q << 4) |
                                   PASSCODE_WIDTH'(bus.keyDigit);
                        count_q <= count_q + 3'd1;
                    end
                end
                ST_CHECK: begin
                    if (match) begin
                        state_q    <= ST_UNLOCKED;
                        unlocked_q <= 1'b1;
                    end else begin
                        state_q <= ST_ERROR;
                        error_q <= 1'b1;
                    end
                end
                ST_UNLOCKED: begin
                    if (bus.keyEnter || bus.keyClear) begin
                        state_q    <= ST_ENTRY;
                        unlocked_q <= 1'b0;
                        entry_q    <= BLANK;
                        count_q    <= '0;
                    end
                end
                ST_ERROR: begin
                    if (timer_done) begin
                        state_q <= ST_ENTRY;
                        error_q <= 1'b0;
                        entry_q <= BLANK;
                        count_q <= '0;
                    end
                end
                default: state_q <= ST_ENTRY;
            endcase
        end
    end

    assign bus.userEntry  = entry_q;
    assign bus.digitCount = count_q;
    assign bus.error      = error_q;
    assign bus.unlocked   = unlocked_q;
endmodule

// File: tb/tb_passcode_entry_controller.sv
// Directed scoreboard bench for passcode_entry_controller
// (ERROR_CYCLES=4, LOCKOUT_CYCLES=8, MAX_ATTEMPTS=3).
module tb_passcode_entry_controller;

    localparam int ERR_LEN = 4;
`ifdef LOCKOUT_EN
    localparam int LOCK_LEN = 12;
`else
    localparam int LOCK_LEN = 4;
`endif

    typedef struct {
        string       tag;
        logic [15:0] entry;
        logic [2:0]  cnt;
        logic        err;
        logic        unl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_asrt = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    passcode_entry_controller_if #(.PASSCODE_WIDTH(16)) bus ();

    passcode_entry_controller #(
        .PASSCODE_LENGTH (4),
        .PASSCODE_WIDTH  (16),
        .PASSCODE        (16'h1234),
        .ERROR_CYCLES    (4),
        .MAX_ATTEMPTS    (3),
        .LOCKOUT_CYCLES  (8)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        n_asrt++;
        assert (bus.userEntry === e.entry) else begin
            n_fail++;
            $error("FAIL %s userEntry got %h expected %h",
                   e.tag, bus.userEntry, e.entry);
        end
        n_asrt++;
        assert (bus.digitCount === e.cnt) else begin
            n_fail++;
            $error("FAIL %s digitCount got %0d expected %0d",
                   e.tag, bus.digitCount, e.cnt);
        end
        n_asrt++;
        assert (bus.error === e.err) else begin
            n_fail++;
            $error("FAIL %s error got %b expected %b",
                   e.tag, bus.error, e.err);
        end
        n_asrt++;
        assert (bus.unlocked === e.unl) else begin
            n_fail++;
            $error("FAIL %s unlocked got %b expected %b",
                   e.tag, bus.unlocked, e.unl);
        end
    endtask

    // One clock: drive at negedge, queue the expectation, sample after posedge.
    task automatic cyc(input logic r, input logic v, input logic [3:0] d,
                       input logic en, input logic cl, input string tag,
                       input logic [15:0] ent, input logic [2:0] cnt,
                       input logic err, input logic unl);
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.keyValid = v;
        bus.keyDigit = d;
        bus.keyEnter = en;
        bus.keyClear = cl;
        e.tag = tag; e.entry = ent; e.cnt = cnt; e.err = err; e.unl = unl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic key(input logic [3:0] d, input string tag,
                       input logic [15:0] ent, input logic [2:0] cnt);
        cyc(0, 1, d, 0, 0, tag, ent, cnt, 0, 0);
    endtask

    task automatic err_hold(input string tag, input logic [15:0] ent,
                            input logic [2:0] cnt, input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, 0, 0, tag, ent, cnt, 1, 0);
        cyc(0, 0, 0, 0, 0, {tag, "_end"}, 16'hEEEE, 0, 0, 0);
    endtask

    initial begin
        bus.keyValid = 0;
        bus.keyDigit = 0;
        bus.keyEnter = 0;
        bus.keyClear = 0;

        cyc(1, 0, 0, 0, 0, "reset0", 16'hEEEE, 0, 0, 0);
        cyc(1, 1, 4'd5, 1, 0, "reset1", 16'hEEEE, 0, 0, 0);

        key(4'd1, "ok_d1", 16'hEEE1, 1);
        key(4'd2, "ok_d2", 16'hEE12, 2);
        key(4'd3, "ok_d3", 16'hE123, 3);
        key(4'd4, "ok_d4", 16'h1234, 4);
        cyc(0, 0, 0, 1, 0, "ok_check", 16'h1234, 4, 0, 0);
        cyc(0, 0, 0, 0, 0, "ok_unlock", 16'h1234, 4, 0, 1);
        cyc(0, 1, 4'd7, 0, 0, "unl_hold", 16'h1234, 4, 0, 1);
        cyc(0, 0, 0, 1, 0, "relock", 16'hEEEE, 0, 0, 0);

        key(4'd1, "ov_d1", 16'hEEE1, 1);
        key(4'd2, "ov_d2", 16'hEE12, 2);
        key(4'd3, "ov_d3", 16'hE123, 3);
        key(4'd4, "ov_d4", 16'h1234, 4);
        key(4'd9, "ov_d5", 16'h1234, 4);
        key(4'hB, "ov_hexB", 16'h1234, 4);
        cyc(0, 0, 0, 0, 1, "ov_clr", 16'hEEEE, 0, 0, 0);
        key(4'hB, "hexB_0", 16'hEEEE, 0);

        key(4'd1, "bad_d1", 16'hEEE1, 1);
        key(4'd2, "bad_d2", 16'hEE12, 2);
        key(4'd3, "bad_d3", 16'hE123, 3);
        key(4'd5, "bad_d4", 16'h1235, 4);
        cyc(0, 0, 0, 1, 0, "bad_check", 16'h1235, 4, 0, 0);
        err_hold("bad_err", 16'h1235, 4, ERR_LEN);

        key(4'd7, "ce_d7", 16'hEEE7, 1);
        key(4'd8, "ce_d8", 16'hEE78, 2);
        cyc(0, 1, 4'd3, 1, 1, "ce_clr", 16'hEEEE, 0, 0, 0);
        key(4'd7, "sh_d7", 16'hEEE7, 1);
        key(4'd8, "sh_d8", 16'hEE78, 2);
        cyc(0, 0, 0, 1, 0, "sh_enter", 16'hEE78, 2, 1, 0);
        cyc(0, 0, 0, 0, 1, "sh_clr_ign", 16'hEE78, 2, 1, 0);
        err_hold("sh_err", 16'hEE78, 2, ERR_LEN - 2);

        key(4'd1, "re_d1", 16'hEEE1, 1);
        cyc(0, 0, 0, 1, 0, "re_err", 16'hEEE1, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, "re_rst_err", 16'hEEEE, 0, 0, 0);
        key(4'd1, "ru_d1", 16'hEEE1, 1);
        key(4'd2, "ru_d2", 16'hEE12, 2);
        key(4'd3, "ru_d3", 16'hE123, 3);
        key(4'd4, "ru_d4", 16'h1234, 4);
        cyc(0, 0, 0, 1, 0, "ru_check", 16'h1234, 4, 0, 0);
        cyc(0, 0, 0, 0, 0, "ru_unl", 16'h1234, 4, 0, 1);
        cyc(1, 0, 0, 0, 0, "ru_rst_unl", 16'hEEEE, 0, 0, 0);

        for (int a = 1; a <= 4; a++) begin
            key(4'd9, $sformatf("lk%0d_d9", a), 16'hEEE9, 1);
            cyc(0, 0, 0, 1, 0, $sformatf("lk%0d_ent", a), 16'hEEE9, 1, 1, 0);
            err_hold($sformatf("lk%0d_err", a), 16'hEEE9, 1,
                     (a == 3 ? LOCK_LEN : ERR_LEN) - 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
